psx_controller: RTL and testbench
=================================

// Module: psx_controller
// PURPOSE
//  Device (controller) end of the PSX pad link. Answers console polls on att/psx_clk/cmd by driving
//  data and ack. Sits between a button-scan source and the PSX connector, and lets the console-side
//  poller be checked against RTL instead of $random data. Oversamples the link on the system clk.
// PARAMETERS
//  SYNC_STAGES   2    flops per input synchronizer (att, psx_clk, cmd)
//  ACK_DELAY     20   clk cycles from the 8th psx_clk rising edge to ack going low
//  ACK_WIDTH     20   clk cycles ack is held low
// PORTS
//  clk           in   1   system clock; must be >= 8x the psx_clk frequency
//  reset         in   1   synchronous, active-high
//  att           in   1   console select, active-low, asynchronous to clk
//  psx_clk       in   1   console shift clock; idles high; asynchronous to clk
//  cmd           in   1   console->pad serial data, LSB first
//  button_state  in   16  active-low buttons; bit0 = first bit sent
//  data          out  1   pad->console serial data, LSB first; idles 1
//  ack           out  1   active-low byte acknowledge; idles 1
//  poll_strobe   out  1   1-cycle pulse when a complete valid poll finishes
//  cmd_error     out  1   sticky until next att fall; header byte mismatch
// BEHAVIOUR
//  Timing and reset
//  - One clk domain. Synchronous active-high reset sets: data=1, ack=1, poll_strobe=0, cmd_error=0,
//    state=IDLE, counters=0.
//  - Edges are detected on synchronized inputs. The pin response is SYNC_STAGES+1 clk cycles after
//    the raw edge.
//  Transaction
//  - att fall: snapshot button_state into shadow regs, load byte 0 and go to SHIFT.
//    Buttons that change mid-poll never tear the reply.
//  - SHIFT: each psx_clk fall drives the next tx bit on data; each psx_clk rise samples cmd into the
//    rx shift reg. Bit count is 0..7.
//  - After the 8th rise, the byte is done:
//    - Check the header: byte0 rx must be 8'h01 and byte1 rx must be 8'h42. On mismatch, set
//      cmd_error, drive data=1, and go to IGNORE. No further acks.
//    - If not the last byte: go to ACK_WAIT for ACK_DELAY cycles, then ACK_PULSE (ack=0) for
//      ACK_WIDTH cycles, then SHIFT with the next byte loaded.
//    - If the last byte: no ack, pulse poll_strobe, go to DONE.
//  - Reply bytes (digital): FF, 41, 5A, btn[7:0], btn[15:8]. Five bytes; ack follows bytes 0-3.
//  - data is driven 1 while waiting for the first falling edge of each byte, and in ACK/DONE/IGNORE.
//  - States: IDLE -> SHIFT -> ACK_WAIT -> ACK_PULSE -> SHIFT ... -> DONE | IGNORE.
//    DONE and IGNORE go to IDLE on att rise.
//  Boundaries
//  - att rise in any state: abort to IDLE in the same cycle it is detected; data=1, ack=1,
//    no poll_strobe. Partial bytes are discarded.
//  - att fall while the previous ack pulse is still active cannot occur: att must rise first.
//  - psx_clk edges during ACK_WAIT/ACK_PULSE are ignored. The console must wait for ack.
//  - Reset mid-poll: immediate idle outputs; the next att fall starts a fresh poll.
//  - Extra psx_clk bytes after the last byte (DONE): data held 1, no ack.
// CONFIGURATION
//  PSX_ANALOG_EN defined:
//  - Adds input ports stick_rx, stick_ry, stick_lx, stick_ly (8 bits each), snapshotted at att fall.
//  - ID byte becomes 8'h73. Reply is FF,73,5A,btn lo,btn hi,rx,ry,lx,ly: nine bytes, acks after
//    bytes 0-7.
//  PSX_ANALOG_EN undefined: no stick ports; digital 5-byte reply as above.
// STRUCTURE
//  - psx_pkg: CMD_START=8'h01, CMD_POLL=8'h42, ID_DIGITAL=8'h41, ID_ANALOG=8'h73, RESP_READY=8'h5A,
//    HIZ_BYTE=8'hFF, state encoding.
//  - Sub-module psx_edge_sync (parameter STAGES): synchronizer plus rise/fall pulse outputs.
//    Instantiated for att and psx_clk; cmd uses sync only.
//  - Top level holds the FSM, byte/bit counters, tx/rx shift registers and the snapshot registers.
// TESTING
//  1 Digital poll: button_state=16'hFFFE, console sends 01,42,00,00,00 ->
//    data bytes FF,41,5A,FE,FF; 4 ack pulses of ACK_WIDTH cycles; poll_strobe once; cmd_error=0.
//  2 Snapshot: button_state changes to 16'h0000 after att fall -> reply still FE,FF; next poll
//    returns 00,00.
//  3 Bad header: byte0=8'h81 -> cmd_error=1 after byte0; no acks; data=1 to att rise;
//    cmd_error clears on next att fall.
//  4 Abort: att rises after bit 3 of byte 2 -> data=1, ack=1 within SYNC_STAGES+2 cycles;
//    no poll_strobe; next poll correct.
//  5 Reset asserted during ACK_PULSE -> ack=1 next cycle; all outputs at reset values.
//  6 PSX_ANALOG_EN with sticks 80,80,80,80 -> FF,73,5A,btn lo,btn hi,80,80,80,80; 8 acks;
//    poll_strobe after byte 8.

Source files
------------

// File: rtl/psx_pkg.sv
// Shared constants, state encoding and helpers for the PSX pad-side controller.
package psx_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned BYTE_CNT_W = 4;
  localparam int unsigned STATE_W    = 3;

  localparam logic [BYTE_W-1:0] CMD_START  = 8'h01;
  localparam logic [BYTE_W-1:0] CMD_POLL   = 8'h42;
  localparam logic [BYTE_W-1:0] ID_DIGITAL = 8'h41;
  localparam logic [BYTE_W-1:0] ID_ANALOG  = 8'h73;
  localparam logic [BYTE_W-1:0] RESP_READY = 8'h5A;
  localparam logic [BYTE_W-1:0] HIZ_BYTE   = 8'hFF;

  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_SHIFT     = 3'd1;
  localparam logic [STATE_W-1:0] ST_ACK_WAIT  = 3'd2;
  localparam logic [STATE_W-1:0] ST_ACK_PULSE = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE      = 3'd4;
  localparam logic [STATE_W-1:0] ST_IGNORE    = 3'd5;

  typedef struct packed {
    logic [BYTE_W-1:0] rx;
    logic [BYTE_W-1:0] ry;
    logic [BYTE_W-1:0] lx;
    logic [BYTE_W-1:0] ly;
  } stick_t;

  // Only the first two console bytes carry a fixed header; the rest are don't-care.
  function automatic logic header_ok(input logic [BYTE_CNT_W-1:0] idx,
                                     input logic [BYTE_W-1:0]     rx);
    case (idx)
      4'd0:    header_ok = (rx == CMD_START);
      4'd1:    header_ok = (rx == CMD_POLL);
      default: header_ok = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/psx_edge_sync.sv
// Multi-flop synchronizer for an asynchronous level with single-cycle rise/fall pulses.
module psx_edge_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] chain_q;
  logic              prev_q;

  // Reset to the idle level so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q <= {STAGES{RESET_VAL}};
      prev_q  <= RESET_VAL;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], din};
      prev_q  <= chain_q[STAGES-1];
    end
  end

  assign rise_c =  chain_q[STAGES-1] & ~prev_q;
  assign fall_c = ~chain_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/psx_controller.sv
// PSX pad (device) end of the att/psx_clk/cmd link, oversampled on clk.
// Define PSX_ANALOG_EN for the 9-byte analog reply with stick inputs.
module psx_controller
  import psx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ACK_DELAY   = 20,
  parameter int unsigned ACK_WIDTH   = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        att,
  input  logic        psx_clk,
  input  logic        cmd,
  input  logic [15:0] button_state,
`ifdef PSX_ANALOG_EN
  input  logic [7:0]  stick_rx,
  input  logic [7:0]  stick_ry,
  input  logic [7:0]  stick_lx,
  input  logic [7:0]  stick_ly,
`endif
  output logic        data,
  output logic        ack,
  output logic        poll_strobe,
  output logic        cmd_error
);

  localparam int unsigned TIMER_MAX = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
  localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);
  localparam int unsigned BTN_W     = 16;

`ifdef PSX_ANALOG_EN
  localparam logic [BYTE_W-1:0]     ID_BYTE   = ID_ANALOG;
  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = 4'd8;
`else
  localparam logic [BYTE_W-1:0]     ID_BYTE   = ID_DIGITAL;
  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = 4'd4;
`endif

  logic att_rise_c, att_fall_c, clk_rise_c, clk_fall_c;
  logic [SYNC_STAGES-1:0] cmd_meta_q;
  logic                   cmd_sync;

  psx_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_att_sync (
    .clk    (clk),
    .reset  (reset),
    .din    (att),
    .rise_c (att_rise_c),
    .fall_c (att_fall_c)
  );

  psx_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_clk_sync (
    .clk    (clk),
    .reset  (reset),
    .din    (psx_clk),
    .rise_c (clk_rise_c),
    .fall_c (clk_fall_c)
  );

  // cmd is only sampled on psx_clk rises, so it needs no edge detection.
  always_ff @(posedge clk) begin
    if (reset) cmd_meta_q <= {SYNC_STAGES{1'b1}};
    else       cmd_meta_q <= {cmd_meta_q[SYNC_STAGES-2:0], cmd};
  end
  assign cmd_sync = cmd_meta_q[SYNC_STAGES-1];

  logic [STATE_W-1:0]    state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic [BYTE_W-1:0]     tx_sr_q, tx_sr_d;
  logic [BYTE_W-2:0]     rx_sr_q, rx_sr_d;
  logic [BTN_W-1:0]      btn_q, btn_d;
  logic                  data_d, ack_d, poll_strobe_d, cmd_error_d;
  logic [BYTE_W-1:0]     rx_byte_c;
  logic [BYTE_W-1:0]     next_byte_c;
  logic [BYTE_CNT_W-1:0] next_idx_c;
`ifdef PSX_ANALOG_EN
  stick_t                stick_q, stick_d;
`endif

  // Reply byte that follows the current one, built from the att-fall snapshot.
  always_comb begin
    next_idx_c  = byte_cnt_q + 4'd1;
    next_byte_c = HIZ_BYTE;
    case (next_idx_c)
      4'd1:    next_byte_c = ID_BYTE;
      4'd2:    next_byte_c = RESP_READY;
      4'd3:    next_byte_c = btn_q[7:0];
      4'd4:    next_byte_c = btn_q[15:8];
`ifdef PSX_ANALOG_EN
      4'd5:    next_byte_c = stick_q.rx;
      4'd6:    next_byte_c = stick_q.ry;
      4'd7:    next_byte_c = stick_q.lx;
      4'd8:    next_byte_c = stick_q.ly;
`endif
      default: next_byte_c = HIZ_BYTE;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    timer_d       = timer_q;
    tx_sr_d       = tx_sr_q;
    rx_sr_d       = rx_sr_q;
    btn_d         = btn_q;
    data_d        = data;
    ack_d         = ack;
    poll_strobe_d = 1'b0;
    cmd_error_d   = cmd_error;
    rx_byte_c     = {cmd_sync, rx_sr_q};
`ifdef PSX_ANALOG_EN
    stick_d       = stick_q;
`endif

    if (att_rise_c) begin
      // Deselect aborts from any state; partial bytes are simply dropped.
      state_d    = ST_IDLE;
      data_d     = 1'b1;
      ack_d      = 1'b1;
      bit_cnt_d  = 3'd0;
      byte_cnt_d = 4'd0;
      timer_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (att_fall_c) begin
            btn_d       = button_state;
`ifdef PSX_ANALOG_EN
            stick_d     = {stick_rx, stick_ry, stick_lx, stick_ly};
`endif
            cmd_error_d = 1'b0;
            tx_sr_d     = HIZ_BYTE;
            bit_cnt_d   = 3'd0;
            byte_cnt_d  = 4'd0;
            data_d      = 1'b1;
            state_d     = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (clk_fall_c) begin
            data_d  = tx_sr_q[0];
            tx_sr_d = {1'b1, tx_sr_q[BYTE_W-1:1]};
          end
          if (clk_rise_c) begin
            rx_sr_d   = rx_byte_c[BYTE_W-1:1];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = 3'd0;
              data_d    = 1'b1;
              if (!header_ok(byte_cnt_q, rx_byte_c)) begin
                cmd_error_d = 1'b1;
                state_d     = ST_IGNORE;
              end else if (byte_cnt_q == LAST_BYTE) begin
                poll_strobe_d = 1'b1;
                state_d       = ST_DONE;
              end else begin
                timer_d = '0;
                state_d = ST_ACK_WAIT;
              end
            end
          end
        end
        ST_ACK_WAIT: begin
          data_d = 1'b1;
          if (timer_q == TIMER_W'(ACK_DELAY - 1)) begin
            timer_d = '0;
            ack_d   = 1'b0;
            state_d = ST_ACK_PULSE;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
        ST_ACK_PULSE: begin
          data_d = 1'b1;
          if (timer_q == TIMER_W'(ACK_WIDTH - 1)) begin
            timer_d    = '0;
            ack_d      = 1'b1;
            byte_cnt_d = next_idx_c;
            tx_sr_d    = next_byte_c;
            bit_cnt_d  = 3'd0;
            state_d    = ST_SHIFT;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
        ST_DONE, ST_IGNORE: begin
          data_d = 1'b1;
          ack_d  = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
          data_d  = 1'b1;
          ack_d   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= 4'd0;
      timer_q     <= '0;
      tx_sr_q     <= HIZ_BYTE;
      rx_sr_q     <= '0;
      btn_q       <= '0;
      data        <= 1'b1;
      ack         <= 1'b1;
      poll_strobe <= 1'b0;
      cmd_error   <= 1'b0;
`ifdef PSX_ANALOG_EN
      stick_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      timer_q     <= timer_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      btn_q       <= btn_d;
      data        <= data_d;
      ack         <= ack_d;
      poll_strobe <= poll_strobe_d;
      cmd_error   <= cmd_error_d;
`ifdef PSX_ANALOG_EN
      stick_q     <= stick_d;
`endif
    end
  end

endmodule

// File: tb/tb_psx_controller.sv
// Console-side bench for psx_controller: drives polls and checks replies against a reply model.
module tb_psx_controller;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned ACK_DELAY   = 20;
  localparam int unsigned ACK_WIDTH   = 20;
  localparam int unsigned HALF        = 8;

`ifdef PSX_ANALOG_EN
  localparam logic [7:0] ID_EXP = 8'h73;
`else
  localparam logic [7:0] ID_EXP = 8'h41;
`endif

  logic        clk = 1'b0;
  logic        reset, att, psx_clk, cmd;
  logic [15:0] button_state;
  logic        data, ack, poll_strobe, cmd_error;
`ifdef PSX_ANALOG_EN
  logic [7:0]  stick_rx = 8'h80, stick_ry = 8'h80, stick_lx = 8'h80, stick_ly = 8'h80;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int strobe_cnt  = 0;
  int ack_low_cnt = 0;

  always #5 clk = ~clk;

  psx_controller #(
    .SYNC_STAGES (SYNC_STAGES),
    .ACK_DELAY   (ACK_DELAY),
    .ACK_WIDTH   (ACK_WIDTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .att          (att),
    .psx_clk      (psx_clk),
    .cmd          (cmd),
    .button_state (button_state),
`ifdef PSX_ANALOG_EN
    .stick_rx     (stick_rx),
    .stick_ry     (stick_ry),
    .stick_lx     (stick_lx),
    .stick_ly     (stick_ly),
`endif
    .data         (data),
    .ack          (ack),
    .poll_strobe  (poll_strobe),
    .cmd_error    (cmd_error)
  );

  always @(negedge clk) begin
    if (poll_strobe === 1'b1) strobe_cnt++;
    if (ack === 1'b0) ack_low_cnt++;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Console shift: fall drives cmd, sample data just before rise; returns right after last rise.
  task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'hFF;
    for (int i = 0; i < nbits; i++) begin
      if (i != 0) repeat (HALF) @(negedge clk);
      psx_clk = 1'b0;
      cmd     = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i]   = data;
      psx_clk = 1'b1;
    end
  endtask

  task automatic wait_ack(output int d, output int w, output bit seen);
    d = 0; w = 0; seen = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (ack === 1'b0) begin d = i; seen = 1'b1; break; end
    end
    if (seen) begin
      w = 1;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (ack === 1'b1) break;
        w++;
      end
    end
  endtask

  task automatic check_ack(input string tag);
    int d, w; bit seen;
    wait_ack(d, w, seen);
    check({tag, "_ack_seen"}, 32'(seen), 1);
    n_assert++;
    assert (seen && d >= int'(ACK_DELAY) && d <= int'(ACK_DELAY + SYNC_STAGES + 3)) else begin
      n_fail++;
      $error("FAIL %s_ack_delay: observed %0d expected %0d..%0d", tag, d, ACK_DELAY,
             ACK_DELAY + SYNC_STAGES + 3);
    end
    check({tag, "_ack_width"}, 32'(w), ACK_WIDTH);
  endtask

  // Full poll; expected reply is the spec's byte list built from the values present at att fall.
  task automatic do_poll(input logic [7:0] b0, input logic [15:0] btn, input logic [15:0] mid_btn,
                         input string tag);
    logic [7:0] exp_q[$];
    logic [7:0] rx, tx;
    int s0, a0;
    bit bad;
    bad   = (b0 != 8'h01);
    exp_q = '{8'hFF, ID_EXP, 8'h5A, btn[7:0], btn[15:8]};
`ifdef PSX_ANALOG_EN
    exp_q.push_back(stick_rx);
    exp_q.push_back(stick_ry);
    exp_q.push_back(stick_lx);
    exp_q.push_back(stick_ly);
`endif
    button_state = btn;
    s0 = strobe_cnt;
    @(negedge clk);
    att = 1'b0;
    repeat (2 * HALF) @(negedge clk);
    check({tag, "_err_clear"}, 32'(cmd_error), 0);
    check({tag, "_pre_data"}, 32'(data), 1);
    button_state = mid_btn;
    for (int k = 0; k < exp_q.size(); k++) begin
      tx = (k == 0) ? b0 : (k == 1) ? 8'h42 : 8'($urandom_range(0, 255));
      xfer_bits(tx, 8, rx);
      if (bad) begin
        repeat (HALF) @(negedge clk);
        check({tag, "_err_set"}, 32'(cmd_error), 1);
        check({tag, "_err_data"}, 32'(data), 1);
        a0 = ack_low_cnt;
        xfer_bits(8'h00, 8, rx);
        repeat (60) @(negedge clk);
        check({tag, "_ignore_rx"}, 32'(rx), 32'hFF);
        check({tag, "_ignore_noack"}, 32'(ack_low_cnt - a0), 0);
        break;
      end
      check($sformatf("%s_byte%0d", tag, k), 32'(rx), 32'(exp_q[k]));
      if (k < exp_q.size() - 1) begin
        check_ack($sformatf("%s_b%0d", tag, k));
        repeat (HALF) @(negedge clk);
      end
    end
    if (!bad) begin
      a0 = ack_low_cnt;
      repeat (60) @(negedge clk);
      check({tag, "_last_noack"}, 32'(ack_low_cnt - a0), 0);
      check({tag, "_strobe"}, 32'(strobe_cnt - s0), 1);
      xfer_bits(8'h00, 8, rx);
      repeat (60) @(negedge clk);
      check({tag, "_extra_rx"}, 32'(rx), 32'hFF);
      check({tag, "_extra_noack"}, 32'(ack_low_cnt - a0), 0);
    end
    check({tag, "_strobe_total"}, 32'(strobe_cnt - s0), bad ? 0 : 1);
    @(negedge clk);
    att = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    check({tag, "_idle_data"}, 32'(data), 1);
    check({tag, "_idle_ack"}, 32'(ack), 1);
    check({tag, "_err_sticky"}, 32'(cmd_error), 32'(bad));
  endtask

  initial begin
    logic [7:0]  rx;
    logic [15:0] rb;
    int s0;
    bit seen;

    reset = 1'b1; att = 1'b1; psx_clk = 1'b1; cmd = 1'b1; button_state = 16'h0000;
    repeat (4) @(negedge clk);
    check("rst_data", 32'(data), 1);
    check("rst_ack", 32'(ack), 1);
    check("rst_strobe", 32'(poll_strobe), 0);
    check("rst_err", 32'(cmd_error), 0);
    reset = 1'b0;
    repeat (8) @(negedge clk);

    do_poll(8'h01, 16'hFFFE, 16'hFFFE, "t1");
    do_poll(8'h01, 16'hFFFE, 16'h0000, "t2a");
    do_poll(8'h01, 16'h0000, 16'h0000, "t2b");
    for (int i = 0; i < 4; i++) begin
      rb = 16'($urandom);
      do_poll(8'h01, rb, 16'($urandom), $sformatf("rnd%0d", i));
    end

    do_poll(8'h81, 16'h1234, 16'h1234, "t3");
    do_poll(8'h01, 16'h5AA5, 16'h5AA5, "t3b");

    // Abort inside byte 2 while data is low
    button_state = 16'hC3C3;
    s0 = strobe_cnt;
    @(negedge clk);
    att = 1'b0;
    repeat (2 * HALF) @(negedge clk);
    xfer_bits(8'h01, 8, rx);
    check("t4_b0", 32'(rx), 32'hFF);
    check_ack("t4_b0");
    repeat (HALF) @(negedge clk);
    xfer_bits(8'h42, 8, rx);
    check("t4_b1", 32'(rx), 32'(ID_EXP));
    check_ack("t4_b1");
    repeat (HALF) @(negedge clk);
    xfer_bits(8'h00, 3, rx);
    repeat (HALF) @(negedge clk);
    check("t4_pre_abort_data", 32'(data), 0);
    att = 1'b1;
    repeat (SYNC_STAGES + 2) @(negedge clk);
    check("t4_abort_data", 32'(data), 1);
    check("t4_abort_ack", 32'(ack), 1);
    repeat (60) @(negedge clk);
    check("t4_no_strobe", 32'(strobe_cnt - s0), 0);
    do_poll(8'h01, 16'h7E81, 16'h7E81, "t4b");

    // Reset while ack is held low
    @(negedge clk);
    att = 1'b0;
    repeat (2 * HALF) @(negedge clk);
    xfer_bits(8'h01, 8, rx);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ack === 1'b0) begin seen = 1'b1; break; end
    end
    check("t5_ack_low", 32'(seen), 1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    att   = 1'b1;
    @(negedge clk);
    check("t5_ack", 32'(ack), 1);
    check("t5_data", 32'(data), 1);
    check("t5_strobe", 32'(poll_strobe), 0);
    check("t5_err", 32'(cmd_error), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2 * HALF) @(negedge clk);
    do_poll(8'h01, 16'hBEEF, 16'hBEEF, "t5b");

`ifdef PSX_ANALOG_EN
    stick_rx = 8'h80; stick_ry = 8'h80; stick_lx = 8'h80; stick_ly = 8'h80;
    do_poll(8'h01, 16'hFFFE, 16'hFFFE, "t6");
    stick_rx = 8'($urandom); stick_ry = 8'($urandom);
    stick_lx = 8'($urandom); stick_ly = 8'($urandom);
    do_poll(8'h01, 16'($urandom), 16'($urandom), "t6r");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
